multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multicycle main control unit that drives the ALU control interface: from the instruction register's opcode and funct it sequences fetch/decode/execute/memory/write-back and produces the 3-bit ALU op plus 6-bit funct consumed by the ALU control decoder, together with datapath strobes. It sits between the instruction register, memory handshake and the datapath of the lab multicycle processor.

## Interface
Parameters:
- RESET_STATE, 4'd0 (FETCH), state entered on reset.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access complete this cycle
- alu_op  out  3  to ALU control: 000 add, 001 sub, 010 R-type (use funct), 011 and, 100 or
- alu_funct  out  6  to ALU control; latched funct in R_EXEC, else 0
- alu_src_a  out  1  0 = PC, 1 = rs
- alu_src_b  out  2  00 rt, 01 const 4, 10 sign-ext imm, 11 imm<<2
- mem_read, mem_write, ir_write, pc_write, reg_write, reg_dst, mem_to_reg  out  1 each
- pc_src  out  2  00 ALU result, 01 ALUOut (branch), 10 jump target
- illegal  out  1  one-cycle pulse on unknown opcode
- state  out  4  current state (debug)

## Operation
- States: FETCH(0), DECODE(1), MEM_ADDR(2), MEM_RD(3), MEM_WB(4), MEM_WR(5), R_EXEC(6), R_WB(7), I_EXEC(8), I_WB(9), BRANCH(10), JUMP(11).
- FETCH: mem_read=1, alu_src_a=0, alu_src_b=01, alu_op=000; stay while mem_ready=0; on mem_ready=1 assert ir_write and pc_write (pc_src=00) that cycle, go DECODE.
- DECODE: alu_src_b=11, alu_op=000 (branch target precompute); funct latched into internal register; dispatch: 100011/101011 -> MEM_ADDR, 000000 -> R_EXEC, 001000/001100/001101 -> I_EXEC, 000100 -> BRANCH, 000010 -> JUMP, other -> illegal=1, FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=000; -> MEM_RD (LW) or MEM_WR (SW).
- MEM_RD/MEM_WR: mem_read / mem_write held until mem_ready=1; then MEM_WB / FETCH.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0 -> FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=010, alu_funct=latched funct -> R_WB; R_WB: reg_write=1, reg_dst=1 -> FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=10, alu_op 000 (ADDI) / 011 (ANDI) / 100 (ORI), opcode latched at DECODE -> I_WB; I_WB: reg_write=1, reg_dst=0 -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=001, pc_src=01, pc_write=zero -> FETCH.
- JUMP: pc_src=10, pc_write=1 -> FETCH.
- Unlisted outputs 0 in every state.

## Timing
- State register updates on rising clk; outputs combinational from state, except ir_write/pc_write in FETCH (gated by mem_ready) and pc_write in BRANCH (gated by zero).
- Instruction latency without wait states: R/ADDI/ANDI/ORI 4, LW 5, SW 4, BEQ 3, J 3, illegal 2 cycles; each mem_ready=0 cycle adds one.
- rst asserted (any time, mid-instruction included): state=FETCH immediately, latched funct/opcode=0, all strobes 0, illegal 0, alu_op=000, alu_funct=0; FETCH outputs appear only after rst deasserts.
- mem_ready ignored outside FETCH/MEM_RD/MEM_WR.

## Configuration
- CTRL_PERF_CNT_EN defined: adds outputs cycle_cnt[31:0] (increments every non-reset cycle) and instr_cnt[31:0] (increments on each transition into FETCH from a terminal state, excluding illegal); both reset to 0, wrap at 2^32.
- Undefined: counters and ports absent; other behaviour identical.

## Structure
- Shared package/header: state encodings, opcode constants, ALU op encodings, alu_src_b and pc_src encodings (also used by ALU control and datapath).
- Sub-module ctrl_out_decode: combinational state-to-strobe decoder; FSM and latches stay in top.

## Test plan
- Reset mid-MEM_RD with rst=1 -> state=0, mem_read=0, alu_op=000 same cycle; after release FETCH, mem_read=1.
- R-type opcode 000000 funct 100010, mem_ready=1 -> state 0,1,6,7,0; alu_op=010, alu_funct=100010 only in R_EXEC; reg_write, reg_dst=1 in R_WB.
- LW 100011 with mem_ready low 2 cycles in MEM_RD -> MEM_RD held 3 cycles, mem_read=1 throughout, then MEM_WB with mem_to_reg=1.
- BEQ 000100 zero=1 then zero=0 -> pc_write=1 / 0 in BRANCH, alu_op=001, pc_src=01.
- Opcode 111111 -> illegal pulse in DECODE, next state FETCH, no reg_write/mem_write.
- With CTRL_PERF_CNT_EN: three ADDI back-to-back -> instr_cnt=3, cycle_cnt=12.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// ============================================================================
// Module   : multicycle_ctrl_pkg
// Purpose  : Shared encodings for the multicycle controller, ALU control and datapath.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXEC   = 4'd6,
        S_R_WB     = 4'd7,
        S_I_EXEC   = 4'd8,
        S_I_WB     = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_RTYPE = 3'b010;
    localparam logic [2:0] ALUOP_AND   = 3'b011;
    localparam logic [2:0] ALUOP_OR    = 3'b100;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic [2:0] alu_op;
        logic [5:0] alu_funct;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic [1:0] pc_src;
        logic       illegal;
    } ctrl_out_t;

    // Unknown opcodes dispatch back to FETCH; that is what flags them illegal.
    function automatic state_t dispatch_state(input logic [5:0] op);
        case (op)
            OP_LW, OP_SW:             return S_MEM_ADDR;
            OP_RTYPE:                 return S_R_EXEC;
            OP_ADDI, OP_ANDI, OP_ORI: return S_I_EXEC;
            OP_BEQ:                   return S_BRANCH;
            OP_J:                     return S_JUMP;
            default:                  return S_FETCH;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_ctrl_out_decode.sv
// ============================================================================
// Module   : ctrl_out_decode
// Purpose  : Combinational state-to-strobe decoder; all outputs forced low in reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ctrl_out_decode
    import multicycle_ctrl_pkg::*;
(
    input  logic       rst,
    input  state_t     state_i,
    input  logic [5:0] opcode_i,
    input  logic [5:0] opcode_q_i,
    input  logic [5:0] funct_q_i,
    input  logic       mem_ready_i,
    input  logic       zero_i,
    output ctrl_out_t  ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        if (!rst) begin
            case (state_i)
                S_FETCH: begin
                    ctrl_o.mem_read  = 1'b1;
                    ctrl_o.alu_src_b = SRCB_FOUR;
                    ctrl_o.ir_write  = mem_ready_i;
                    ctrl_o.pc_write  = mem_ready_i;
                end
                S_DECODE: begin
                    ctrl_o.alu_src_b = SRCB_IMM_SH;
                    ctrl_o.illegal   = (dispatch_state(opcode_i) == S_FETCH);
                end
                S_MEM_ADDR: begin
                    ctrl_o.alu_src_a = 1'b1;
                    ctrl_o.alu_src_b = SRCB_IMM;
                end
                S_MEM_RD: ctrl_o.mem_read  = 1'b1;
                S_MEM_WR: ctrl_o.mem_write = 1'b1;
                S_MEM_WB: begin
                    ctrl_o.reg_write  = 1'b1;
                    ctrl_o.mem_to_reg = 1'b1;
                end
                S_R_EXEC: begin
                    ctrl_o.alu_src_a = 1'b1;
                    ctrl_o.alu_src_b = SRCB_RT;
                    ctrl_o.alu_op    = ALUOP_RTYPE;
                    ctrl_o.alu_funct = funct_q_i;
                end
                S_R_WB: begin
                    ctrl_o.reg_write = 1'b1;
                    ctrl_o.reg_dst   = 1'b1;
                end
                S_I_EXEC: begin
                    ctrl_o.alu_src_a = 1'b1;
                    ctrl_o.alu_src_b = SRCB_IMM;
                    case (opcode_q_i)
                        OP_ANDI: ctrl_o.alu_op = ALUOP_AND;
                        OP_ORI:  ctrl_o.alu_op = ALUOP_OR;
                        default: ctrl_o.alu_op = ALUOP_ADD;
                    endcase
                end
                S_I_WB: ctrl_o.reg_write = 1'b1;
                S_BRANCH: begin
                    ctrl_o.alu_src_a = 1'b1;
                    ctrl_o.alu_src_b = SRCB_RT;
                    ctrl_o.alu_op    = ALUOP_SUB;
                    ctrl_o.pc_src    = PCSRC_ALUOUT;
                    ctrl_o.pc_write  = zero_i;
                end
                S_JUMP: begin
                    ctrl_o.pc_src   = PCSRC_JUMP;
                    ctrl_o.pc_write = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// ============================================================================
// Module   : multicycle_ctrl
// Purpose  : Multicycle main control FSM; CTRL_PERF_CNT_EN adds cycle/instr counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        mem_ready,
    output logic [2:0]  alu_op,
    output logic [5:0]  alu_funct,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        pc_write,
    output logic        reg_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic [1:0]  pc_src,
    output logic        illegal,
    output logic [3:0]  state
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instr_cnt
`endif
);

    state_t     state_q, state_d;
    logic [5:0] opcode_q, opcode_d;
    logic [5:0] funct_q, funct_d;
    ctrl_out_t  w_ctrl;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= state_t'(RESET_STATE);
            opcode_q <= '0;
            funct_q  <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            funct_q  <= funct_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        funct_d  = funct_q;
        case (state_q)
            S_FETCH:    if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                opcode_d = opcode;
                funct_d  = funct;
                state_d  = dispatch_state(opcode);
            end
            S_MEM_ADDR: state_d = (opcode_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (mem_ready) state_d = S_MEM_WB;
            S_MEM_WR:   if (mem_ready) state_d = S_FETCH;
            S_R_EXEC:   state_d = S_R_WB;
            S_I_EXEC:   state_d = S_I_WB;
            default:    state_d = S_FETCH;
        endcase
    end

    ctrl_out_decode u_decode (
        .rst         (rst),
        .state_i     (state_q),
        .opcode_i    (opcode),
        .opcode_q_i  (opcode_q),
        .funct_q_i   (funct_q),
        .mem_ready_i (mem_ready),
        .zero_i      (zero),
        .ctrl_o      (w_ctrl)
    );

    assign alu_op     = w_ctrl.alu_op;
    assign alu_funct  = w_ctrl.alu_funct;
    assign alu_src_a  = w_ctrl.alu_src_a;
    assign alu_src_b  = w_ctrl.alu_src_b;
    assign mem_read   = w_ctrl.mem_read;
    assign mem_write  = w_ctrl.mem_write;
    assign ir_write   = w_ctrl.ir_write;
    assign pc_write   = w_ctrl.pc_write;
    assign reg_write  = w_ctrl.reg_write;
    assign reg_dst    = w_ctrl.reg_dst;
    assign mem_to_reg = w_ctrl.mem_to_reg;
    assign pc_src     = w_ctrl.pc_src;
    assign illegal    = w_ctrl.illegal;
    assign state      = state_q;

`ifdef CTRL_PERF_CNT_EN
    logic [31:0] cycle_cnt_q;
    logic [31:0] instr_cnt_q;
    logic        w_instr_done;

    // Any return to FETCH from beyond DECODE is a retired instruction; illegal ones return from DECODE.
    assign w_instr_done = (state_q != S_FETCH) && (state_q != S_DECODE) && (state_d == S_FETCH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_q + 32'd1;
            if (w_instr_done) instr_cnt_q <= instr_cnt_q + 32'd1;
        end
    end

    assign cycle_cnt = cycle_cnt_q;
    assign instr_cnt = instr_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// ============================================================================
// Module   : tb_multicycle_ctrl
// Purpose  : Table-driven self-checking bench for multicycle_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_ctrl;
    import multicycle_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic [2:0] alu_op;
    logic [5:0] alu_funct;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       mem_read, mem_write, ir_write, pc_write, reg_write, reg_dst, mem_to_reg;
    logic [1:0] pc_src;
    logic       illegal;
    logic [3:0] state;
`ifdef CTRL_PERF_CNT_EN
    logic [31:0] cycle_cnt, instr_cnt;
`endif

    multicycle_ctrl #(.RESET_STATE(4'd0)) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .alu_op     (alu_op),
        .alu_funct  (alu_funct),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .pc_src     (pc_src),
        .illegal    (illegal),
        .state      (state)
`ifdef CTRL_PERF_CNT_EN
        ,
        .cycle_cnt  (cycle_cnt),
        .instr_cnt  (instr_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Output vector layout: {alu_op, alu_funct, src_a, src_b, strobes[6:0], pc_src, illegal}
    // strobes = {mem_read, mem_write, ir_write, pc_write, reg_write, reg_dst, mem_to_reg}
    typedef struct {
        logic        r;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic        rdy;
        logic [3:0]  exp_state;
        logic [21:0] exp_out;
    } vec_t;

    localparam logic [6:0] SB_NONE  = 7'b0000000;
    localparam logic [6:0] SB_MR    = 7'b1000000;
    localparam logic [6:0] SB_FETCH = 7'b1011000;
    localparam logic [6:0] SB_MW    = 7'b0100000;
    localparam logic [6:0] SB_PCW   = 7'b0001000;
    localparam logic [6:0] SB_RWB   = 7'b0000110;
    localparam logic [6:0] SB_IWB   = 7'b0000100;
    localparam logic [6:0] SB_MWB   = 7'b0000101;

    int compared = 0;
    int mismatched = 0;
    vec_t v[$];

    function automatic vec_t mk(input logic r, input logic [5:0] op, input logic [5:0] fn,
                                input logic z, input logic rdy, input logic [3:0] st,
                                input logic [2:0] aop, input logic [5:0] afn, input logic sa,
                                input logic [1:0] sb, input logic [6:0] stb,
                                input logic [1:0] pcs, input logic ill);
        vec_t t;
        t.r = r; t.op = op; t.fn = fn; t.z = z; t.rdy = rdy;
        t.exp_state = st;
        t.exp_out = {aop, afn, sa, sb, stb, pcs, ill};
        return t;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    logic [21:0] act_out;
    assign act_out = {alu_op, alu_funct, alu_src_a, alu_src_b, mem_read, mem_write, ir_write,
                      pc_write, reg_write, reg_dst, mem_to_reg, pc_src, illegal};

    initial begin
        // Reset
        v.push_back(mk(1'b1, OP_RTYPE, 6'd0, 1'b0, 1'b1, 4'd0, 3'b000, 6'd0, 1'b0, 2'b00, SB_NONE, 2'b00, 1'b0));
        // R-type SUB; funct input changes in R_EXEC to prove the latch
        v.push_back(mk(1'b0, OP_RTYPE, 6'b100010, 1'b0, 1'b1, 4'd0, 3'b000, 6'd0, 1'b0, 2'b01, SB_FETCH, 2'b00, 1'b0));
        v.push_back(mk(1'b0, OP_RTYPE, 6'b100010, 1'b0, 1'b1, 4'd1, 3'b000, 6'd0, 1'b0, 2'b11, SB_NONE, 2'b00, 1'b0));
        v.push_back(mk(1'b0, OP_RTYPE, 6'b000000, 1'b0, 1'b1, 4'd6, 3'b010, 6'b100010, 1'b1, 2'b00, SB_NONE, 2'b00, 1'b0));
        v.push_back(mk(1'b0, OP_RTYPE, 6'b000000, 1'b0, 1'b1, 4'd7, 3'b000, 6'd0, 1'b0, 2'b00, SB_RWB, 2'b00, 1'b0));
        // LW with one FETCH wait and two MEM_RD waits
        v.push_back(mk(1'b0, OP_LW, 6'd0, 1'b0, 1'b0, 4'd0, 3'b000, 6'd0, 1'b0, 2'b01, SB_MR, 2'b00, 1'b0));
        v.push_back(mk(1'b0, OP_LW, 6'd0, 1'b0, 1'b1, 4'd0, 3'b000, 6'd0, 1'b0, 2'b01, SB_FETCH, 2'b00, 1'b0));
        v.push_back(mk(1'b0, OP_LW, 6'd0, 1'b0, 1'b1, 4'd1, 3'b000, 6'd0, 1'b0, 2'b11, SB_NONE, 2'b00, 1'b0));
        v.push_back(mk(1'b0, OP_LW, 6'd0, 1'b0, 1'b1, 4'd2, 3'b000, 6'd0, 1'b1, 2'b10, SB_NONE, 2'b00, 1'b0));
        v.push_back(mk(1'b0, OP_LW, 6'd0, 1'b0, 1'b0, 4'd3, 3'b000, 6'd0, 1'b0, 2'b00, SB_MR, 2'b00, 1'b0));
        v.push_back(mk(1'b0, OP_LW, 6'd0, 1'b0, 1'b0, 4'd3, 3'b000, 6'd0, 1'b0, 2'b00, SB_MR, 2'b00, 1'b0));
        v.push_back(mk(1'b0, OP_LW, 6'd0, 1'b0, 1'b1, 4'd3, 3'b000, 6'd0, 1'b0, 2'b00, SB_MR, 2'b00, 1'b0));
        v.push_back(mk(1'b0, OP_LW, 6'd0, 1'b0, 1'b1, 4'd4, 3'b000, 6'd0, 1'b0, 2'b00, SB_MWB, 2'b00, 1'b0));
        // BEQ taken then not taken
        v.push_back(mk(1'b0, OP_BEQ, 6'd0, 1'b1, 1'b1, 4'd0, 3'b000, 6'd0, 1'b0, 2'b01, SB_FETCH, 2'b00, 1'b0));
        v.push_back(mk(1'b0, OP_BEQ, 6'd0, 1'b1, 1'b1, 4'd1, 3'b000, 6'd0, 1'b0, 2'b11, SB_NONE, 2'b00, 1'b0));
        v.push_back(mk(1'b0, OP_BEQ, 6'd0, 1'b1, 1'b1, 4'd10, 3'b001, 6'd0, 1'b1, 2'b00, SB_PCW, 2'b01, 1'b0));
        v.push_back(mk(1'b0, OP_BEQ, 6'd0, 1'b0, 1'b1, 4'd0, 3'b000, 6'd0, 1'b0, 2'b01, SB_FETCH, 2'b00, 1'b0));
        v.push_back(mk(1'b0, OP_BEQ, 6'd0, 1'b0, 1'b1, 4'd1, 3'b000, 6'd0, 1'b0, 2'b11, SB_NONE, 2'b00, 1'b0));
        v.push_back(mk(1'b0, OP_BEQ, 6'd0, 1'b0, 1'b1, 4'd10, 3'b001, 6'd0, 1'b1, 2'b00, SB_NONE, 2'b01, 1'b0));
        // Illegal opcode: pulse in DECODE, back to FETCH
        v.push_back(mk(1'b0, 6'b111111, 6'd0, 1'b0, 1'b1, 4'd0, 3'b000, 6'd0, 1'b0, 2'b01, SB_FETCH, 2'b00, 1'b0));
        v.push_back(mk(1'b0, 6'b111111, 6'd0, 1'b0, 1'b1, 4'd1, 3'b000, 6'd0, 1'b0, 2'b11, SB_NONE, 2'b00, 1'b1));
        v.push_back(mk(1'b0, 6'b111111, 6'd0, 1'b0, 1'b0, 4'd0, 3'b000, 6'd0, 1'b0, 2'b01, SB_MR, 2'b00, 1'b0));
        // SW
        v.push_back(mk(1'b0, OP_SW, 6'd0, 1'b0, 1'b1, 4'd0, 3'b000, 6'd0, 1'b0, 2'b01, SB_FETCH, 2'b00, 1'b0));
        v.push_back(mk(1'b0, OP_SW, 6'd0, 1'b0, 1'b1, 4'd1, 3'b000, 6'd0, 1'b0, 2'b11, SB_NONE, 2'b00, 1'b0));
        v.push_back(mk(1'b0, OP_SW, 6'd0, 1'b0, 1'b1, 4'd2, 3'b000, 6'd0, 1'b1, 2'b10, SB_NONE, 2'b00, 1'b0));
        v.push_back(mk(1'b0, OP_SW, 6'd0, 1'b0, 1'b1, 4'd5, 3'b000, 6'd0, 1'b0, 2'b00, SB_MW, 2'b00, 1'b0));
        // ORI; live opcode changes in I_EXEC to prove the latch
        v.push_back(mk(1'b0, OP_ORI, 6'd0, 1'b0, 1'b1, 4'd0, 3'b000, 6'd0, 1'b0, 2'b01, SB_FETCH, 2'b00, 1'b0));
        v.push_back(mk(1'b0, OP_ORI, 6'd0, 1'b0, 1'b1, 4'd1, 3'b000, 6'd0, 1'b0, 2'b11, SB_NONE, 2'b00, 1'b0));
        v.push_back(mk(1'b0, OP_RTYPE, 6'd0, 1'b0, 1'b1, 4'd8, 3'b100, 6'd0, 1'b1, 2'b10, SB_NONE, 2'b00, 1'b0));
        v.push_back(mk(1'b0, OP_RTYPE, 6'd0, 1'b0, 1'b1, 4'd9, 3'b000, 6'd0, 1'b0, 2'b00, SB_IWB, 2'b00, 1'b0));
        // ANDI
        v.push_back(mk(1'b0, OP_ANDI, 6'd0, 1'b0, 1'b1, 4'd0, 3'b000, 6'd0, 1'b0, 2'b01, SB_FETCH, 2'b00, 1'b0));
        v.push_back(mk(1'b0, OP_ANDI, 6'd0, 1'b0, 1'b1, 4'd1, 3'b000, 6'd0, 1'b0, 2'b11, SB_NONE, 2'b00, 1'b0));
        v.push_back(mk(1'b0, OP_ANDI, 6'd0, 1'b0, 1'b1, 4'd8, 3'b011, 6'd0, 1'b1, 2'b10, SB_NONE, 2'b00, 1'b0));
        v.push_back(mk(1'b0, OP_ANDI, 6'd0, 1'b0, 1'b1, 4'd9, 3'b000, 6'd0, 1'b0, 2'b00, SB_IWB, 2'b00, 1'b0));
        // J
        v.push_back(mk(1'b0, OP_J, 6'd0, 1'b0, 1'b1, 4'd0, 3'b000, 6'd0, 1'b0, 2'b01, SB_FETCH, 2'b00, 1'b0));
        v.push_back(mk(1'b0, OP_J, 6'd0, 1'b0, 1'b1, 4'd1, 3'b000, 6'd0, 1'b0, 2'b11, SB_NONE, 2'b00, 1'b0));
        v.push_back(mk(1'b0, OP_J, 6'd0, 1'b0, 1'b1, 4'd11, 3'b000, 6'd0, 1'b0, 2'b00, SB_PCW, 2'b10, 1'b0));
        // LW interrupted by asynchronous reset in MEM_RD
        v.push_back(mk(1'b0, OP_LW, 6'd0, 1'b0, 1'b1, 4'd0, 3'b000, 6'd0, 1'b0, 2'b01, SB_FETCH, 2'b00, 1'b0));
        v.push_back(mk(1'b0, OP_LW, 6'd0, 1'b0, 1'b1, 4'd1, 3'b000, 6'd0, 1'b0, 2'b11, SB_NONE, 2'b00, 1'b0));
        v.push_back(mk(1'b0, OP_LW, 6'd0, 1'b0, 1'b1, 4'd2, 3'b000, 6'd0, 1'b1, 2'b10, SB_NONE, 2'b00, 1'b0));
        v.push_back(mk(1'b0, OP_LW, 6'd0, 1'b0, 1'b0, 4'd3, 3'b000, 6'd0, 1'b0, 2'b00, SB_MR, 2'b00, 1'b0));
        v.push_back(mk(1'b1, OP_LW, 6'd0, 1'b0, 1'b0, 4'd0, 3'b000, 6'd0, 1'b0, 2'b00, SB_NONE, 2'b00, 1'b0));
        v.push_back(mk(1'b0, OP_LW, 6'd0, 1'b0, 1'b0, 4'd0, 3'b000, 6'd0, 1'b0, 2'b01, SB_MR, 2'b00, 1'b0));
        // ADDI
        v.push_back(mk(1'b0, OP_ADDI, 6'd0, 1'b0, 1'b1, 4'd0, 3'b000, 6'd0, 1'b0, 2'b01, SB_FETCH, 2'b00, 1'b0));
        v.push_back(mk(1'b0, OP_ADDI, 6'd0, 1'b0, 1'b1, 4'd1, 3'b000, 6'd0, 1'b0, 2'b11, SB_NONE, 2'b00, 1'b0));
        v.push_back(mk(1'b0, OP_ADDI, 6'd0, 1'b0, 1'b1, 4'd8, 3'b000, 6'd0, 1'b1, 2'b10, SB_NONE, 2'b00, 1'b0));
        v.push_back(mk(1'b0, OP_ADDI, 6'd0, 1'b0, 1'b1, 4'd9, 3'b000, 6'd0, 1'b0, 2'b00, SB_IWB, 2'b00, 1'b0));

        for (int i = 0; i < v.size(); i++) begin
            rst       = v[i].r;
            opcode    = v[i].op;
            funct     = v[i].fn;
            zero      = v[i].z;
            mem_ready = v[i].rdy;
            @(negedge clk);
            chk("state", i, {28'd0, state}, {28'd0, v[i].exp_state});
            chk("outputs", i, {10'd0, act_out}, {10'd0, v[i].exp_out});
            @(posedge clk);
            #1;
        end

        // Asynchronous reset pulse between clock edges while in DECODE
        rst = 1'b0; opcode = OP_RTYPE; mem_ready = 1'b1;
        @(posedge clk); #1;
        chk("async_pre_state", 0, {28'd0, state}, 32'd1);
        rst = 1'b1; #1;
        chk("async_state", 0, {28'd0, state}, 32'd0);
        chk("async_outputs", 0, {10'd0, act_out}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("async_release", 0, {10'd0, act_out}, {10'd0, 3'b000, 6'd0, 1'b0, 2'b01, SB_FETCH, 2'b00, 1'b0});

`ifdef CTRL_PERF_CNT_EN
        // Three back-to-back ADDI instructions from reset
        rst = 1'b1; opcode = OP_ADDI; mem_ready = 1'b1;
        @(posedge clk); #1;
        chk("cnt_reset_cycle", 0, cycle_cnt, 32'd0);
        chk("cnt_reset_instr", 0, instr_cnt, 32'd0);
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("cycle_cnt", 0, cycle_cnt, 32'd12);
        chk("instr_cnt", 0, instr_cnt, 32'd3);
        chk("cnt_state", 0, {28'd0, state}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

`default_nettype wire
